mod7_seq_monitor: RTL and testbench
===================================

Name: mod7_seq_monitor

Overview:
Downstream checker for the 3-bit JK-built mod-7 state counter, whose legal sequence is 0→1→2→3→4→5→6→0 with code 7 illegal. It samples the counter's state bus every enabled clock and locks once the sequence has been followed for a set number of steps. While locked it counts full cycles (wraps) and flags any broken transition. Outputs feed the lab status LEDs and the optional display.

Parameters:
LOCK_CNT, 3, consecutive correct transitions required to enter LOCK (range 1..7)
WRAP_W, 8, width of wrap counter
ERR_W, 4, width of saturating error counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; asynchronous, active-low
en  input  1  sample enable; when 0 all state holds
clr  input  1  synchronous clear of fault and wrap count
state_in  input  3  counter state {A,B,C} under observation
locked  output  1  high in LOCK state
fault  output  1  high in FAULT state (sticky)
wrap_cnt  output  WRAP_W  number of 6→0 transitions seen while locked, modulo 2^WRAP_W
err_cnt  output  ERR_W  number of LOCK→FAULT entries, saturating at all-ones
last_state  output  3  registered copy of the last sampled state_in

Behaviour:
- Reset (rst=0, async): FSM=HUNT; last_state=0; have_prev=0; run_cnt=0; wrap_cnt=0; err_cnt=0; locked=0; fault=0.
- nxt(s) is 0 if s==6, otherwise s+1. Define nxt(7)=7 as a poison value; any sample of 7 is a mismatch.
- match is (have_prev && state_in==nxt(last_state) && state_in!=7).
- On each rising edge with en=1 and clr=0:
  - last_state is set to state_in.
  - have_prev is set to 1.
- HUNT:
  - If match, run_cnt increments; otherwise run_cnt=0.
  - When the incremented run_cnt reaches LOCK_CNT, go to LOCK and clear run_cnt.
- LOCK:
  - If match, stay. If additionally last_state==6 and state_in==0, wrap_cnt increments and wraps freely.
  - If mismatch, go to FAULT; err_cnt increments and saturates.
- FAULT: holds until clr.
- Outputs are registered. locked and fault are decoded from FSM state, so they update at the same edge as the state change.
- Latency: locked rises on the edge that samples the LOCK_CNT-th correct transition. fault rises on the edge that samples the first bad value.
- clr=1 (sync, any state): FSM=HUNT; run_cnt=0; have_prev=0; wrap_cnt=0; fault=0.
  - err_cnt is NOT cleared; only rst clears it.
  - clr has priority over en, and the sample in that cycle is discarded.
- en=0: no register changes; clr still acts.
- Holding state (state_in unchanged) counts as a mismatch. A stalled counter is therefore a fault when locked, and resets run_cnt in HUNT.
- Async reset asserted mid-operation returns to the reset values immediately, independent of clk.
- FSM encoding: 2 bits. HUNT=0, LOCK=1, FAULT=2. Unused code 3 recovers to HUNT on the next enabled edge.

Optional Feature:
Macro: MOD7_SEG_DECODE_EN
- Defined: adds output seg (7 bits, active-high, segments a..g). It carries the registered 7-segment pattern of last_state, showing digits 0–6 and "E" for code 7. seg resets to the pattern for 0, updates on the same edge as last_state, and shows "-" (g only) while fault=1.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package: FSM state constants (HUNT, LOCK, FAULT); MOD7_LAST=3'd6; MOD7_ILLEGAL=3'd7; 7-segment pattern constants.
- One natural sub-module: mod7_seg7_dec, a combinational 3-bit to 7-segment decoder. It is instantiated only under MOD7_SEG_DECODE_EN and registered in the parent.

Test Plan:
- Reset, then drive state_in=0,1,2,3 on four enabled edges (LOCK_CNT=3) → locked=1 after the 4th edge; fault=0; wrap_cnt=0; last_state=3.
- Locked, run 0..6 sequence for 21 more edges including three 6→0 steps → wrap_cnt=3, err_cnt=0.
- Locked, inject state_in=5 when 4 is expected → fault=1 and locked=0 on that edge, err_cnt=1. Continue a valid sequence → fault stays 1.
- In FAULT, pulse clr together with en=1 and state_in=2 → FSM=HUNT, fault=0, wrap_cnt=0, err_cnt=1, last_state unchanged. Relock needs 4 more good samples.
- Locked, drive state_in=7 → fault=1. With MOD7_SEG_DECODE_EN defined, seg shows "-". Sixteen more fault/clr/relock rounds → err_cnt saturates at 15.
- Assert rst low asynchronously mid-cycle while locked with wrap_cnt=5 → all outputs 0 immediately, before the next clk edge. Hold en=0 for 10 edges after release → nothing changes.

Source files
------------

// File: rtl/mod7_seq_monitor_pkg.sv
// Shared definitions for the mod-7 sequence monitor: FSM states, counter codes,
// 7-segment patterns ({a,b,c,d,e,f,g}, active-high) and the successor function.
package mod7_seq_monitor_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LOCK  = 2'd1,
        FAULT = 2'd2,
        SPARE = 2'd3
    } fsm_t;

    localparam logic [2:0] MOD7_LAST    = 3'd6;
    localparam logic [2:0] MOD7_ILLEGAL = 3'd7;

    localparam logic [6:0] SEG_0    = 7'b1111110;
    localparam logic [6:0] SEG_1    = 7'b0110000;
    localparam logic [6:0] SEG_2    = 7'b1101101;
    localparam logic [6:0] SEG_3    = 7'b1111001;
    localparam logic [6:0] SEG_4    = 7'b0110011;
    localparam logic [6:0] SEG_5    = 7'b1011011;
    localparam logic [6:0] SEG_6    = 7'b1011111;
    localparam logic [6:0] SEG_E    = 7'b1001111;
    localparam logic [6:0] SEG_DASH = 7'b0000001;

    // The illegal code maps to itself so that it can never be a valid successor.
    function automatic logic [2:0] mod7_nxt(input logic [2:0] s);
        if (s == MOD7_ILLEGAL)
            return MOD7_ILLEGAL;
        else if (s == MOD7_LAST)
            return 3'd0;
        else
            return s + 3'd1;
    endfunction

endpackage

// File: rtl/mod7_seg7_dec.sv
// Combinational 3-bit code to 7-segment decoder; digits 0-6, "E" for code 7.
// Only compiled when MOD7_SEG_DECODE_EN is defined.
`ifdef MOD7_SEG_DECODE_EN
module mod7_seg7_dec
    import mod7_seq_monitor_pkg::*;
(
    input  logic [2:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_E;
        case (code)
            3'd0: seg = SEG_0;
            3'd1: seg = SEG_1;
            3'd2: seg = SEG_2;
            3'd3: seg = SEG_3;
            3'd4: seg = SEG_4;
            3'd5: seg = SEG_5;
            3'd6: seg = SEG_6;
            default: seg = SEG_E;
        endcase
    end

endmodule
`endif

// File: rtl/mod7_seq_monitor.sv
// Lock/fault monitor for a mod-7 state counter bus (0..6, 7 illegal).
// Optional 7-segment output of the last sample under MOD7_SEG_DECODE_EN.
module mod7_seq_monitor
    import mod7_seq_monitor_pkg::*;
#(
    parameter int LOCK_CNT = 3,
    parameter int WRAP_W   = 8,
    parameter int ERR_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [2:0]        state_in,
    output logic              locked,
    output logic              fault,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic [ERR_W-1:0]  err_cnt,
`ifdef MOD7_SEG_DECODE_EN
    output logic [6:0]        seg,
`endif
    output logic [2:0]        last_state
);

    localparam logic [2:0] LOCK_TGT = 3'(LOCK_CNT);

    fsm_t              fsm_reg, fsm_next;
    logic [2:0]        run_cnt_reg, run_cnt_next;
    logic [WRAP_W-1:0] wrap_cnt_reg, wrap_cnt_next;
    logic [ERR_W-1:0]  err_cnt_reg, err_cnt_next;
    logic [2:0]        last_state_reg;
    logic              have_prev_reg;
    logic              match;
    logic [2:0]        run_inc;

    assign match   = have_prev_reg
                   && (state_in == mod7_nxt(last_state_reg))
                   && (state_in != MOD7_ILLEGAL);
    assign run_inc = run_cnt_reg + 3'd1;

    always_comb begin
        fsm_next      = fsm_reg;
        run_cnt_next  = run_cnt_reg;
        wrap_cnt_next = wrap_cnt_reg;
        err_cnt_next  = err_cnt_reg;
        case (fsm_reg)
            HUNT: begin
                if (match) begin
                    if (run_inc == LOCK_TGT) begin
                        fsm_next     = LOCK;
                        run_cnt_next = '0;
                    end else begin
                        run_cnt_next = run_inc;
                    end
                end else begin
                    run_cnt_next = '0;
                end
            end
            LOCK: begin
                if (match) begin
                    if (last_state_reg == MOD7_LAST && state_in == 3'd0)
                        wrap_cnt_next = wrap_cnt_reg + 1'b1;
                end else begin
                    fsm_next = FAULT;
                    if (err_cnt_reg != '1)
                        err_cnt_next = err_cnt_reg + 1'b1;
                end
            end
            FAULT: fsm_next = FAULT;
            default: begin
                fsm_next     = HUNT;
                run_cnt_next = '0;
            end
        endcase
    end

    // clr wins over en and discards the sample; err_cnt survives clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_reg        <= HUNT;
            run_cnt_reg    <= '0;
            wrap_cnt_reg   <= '0;
            err_cnt_reg    <= '0;
            last_state_reg <= '0;
            have_prev_reg  <= 1'b0;
        end else if (clr) begin
            fsm_reg       <= HUNT;
            run_cnt_reg   <= '0;
            wrap_cnt_reg  <= '0;
            have_prev_reg <= 1'b0;
        end else if (en) begin
            fsm_reg        <= fsm_next;
            run_cnt_reg    <= run_cnt_next;
            wrap_cnt_reg   <= wrap_cnt_next;
            err_cnt_reg    <= err_cnt_next;
            last_state_reg <= state_in;
            have_prev_reg  <= 1'b1;
        end
    end

    assign locked     = (fsm_reg == LOCK);
    assign fault      = (fsm_reg == FAULT);
    assign wrap_cnt   = wrap_cnt_reg;
    assign err_cnt    = err_cnt_reg;
    assign last_state = last_state_reg;

`ifdef MOD7_SEG_DECODE_EN
    logic [6:0] seg_reg;
    logic [6:0] seg_pat;

    mod7_seg7_dec u_seg_dec (
        .code (state_in),
        .seg  (seg_pat)
    );

    // Tracks last_state exactly: same reset, same enable, untouched by clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            seg_reg <= SEG_0;
        else if (!clr && en)
            seg_reg <= seg_pat;
    end

    assign seg = (fsm_reg == FAULT) ? SEG_DASH : seg_reg;
`endif

endmodule

// File: tb/tb_mod7_seq_monitor.sv
// Self-checking bench for mod7_seq_monitor: directed vector table, hand-written
// saturation/async-reset sequences and a randomized run against a history model.
module tb_mod7_seq_monitor;

    localparam int LOCK_CNT = 3;
    localparam int WRAP_W   = 8;
    localparam int ERR_W    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              clr;
    logic [2:0]        state_in;
    logic              locked;
    logic              fault;
    logic [WRAP_W-1:0] wrap_cnt;
    logic [ERR_W-1:0]  err_cnt;
    logic [2:0]        last_state;
`ifdef MOD7_SEG_DECODE_EN
    logic [6:0]        seg;
`endif

    mod7_seq_monitor #(
        .LOCK_CNT (LOCK_CNT),
        .WRAP_W   (WRAP_W),
        .ERR_W    (ERR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clr        (clr),
        .state_in   (state_in),
        .locked     (locked),
        .fault      (fault),
        .wrap_cnt   (wrap_cnt),
        .err_cnt    (err_cnt),
`ifdef MOD7_SEG_DECODE_EN
        .seg        (seg),
`endif
        .last_state (last_state)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int l, input int f, input int w,
                           input int e, input int last);
        chk({tag, ".locked"},     32'(locked),     32'(l));
        chk({tag, ".fault"},      32'(fault),      32'(f));
        chk({tag, ".wrap_cnt"},   32'(wrap_cnt),   32'(w));
        chk({tag, ".err_cnt"},    32'(err_cnt),    32'(e));
        chk({tag, ".last_state"}, 32'(last_state), 32'(last));
    endtask

    task automatic drive(input logic e, input logic c, input logic [2:0] s);
        en       = e;
        clr      = c;
        state_in = s;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            default: return 7'b1001111;
        endcase
    endfunction

    // Reference model: history of accepted samples since the last clear plus an
    // unbounded streak of good transitions; locked means streak >= LOCK_CNT.
    int q_hist[$];
    int m_streak;
    bit m_fault;
    int m_wrap;
    int m_err;
    int m_last;

    function automatic void model_reset();
        q_hist.delete();
        m_streak = 0;
        m_fault  = 0;
        m_wrap   = 0;
        m_err    = 0;
        m_last   = 0;
    endfunction

    function automatic void model_step(input bit e, input bit c, input int s);
        int  prev;
        bit  good;
        bit  was_locked;
        if (c) begin
            q_hist.delete();
            m_streak = 0;
            m_fault  = 0;
            m_wrap   = 0;
            return;
        end
        if (!e) return;
        prev       = (q_hist.size() > 0) ? q_hist[$] : -1;
        good       = (prev >= 0) && (prev != 7) && (s != 7) && (s == (prev + 1) % 7);
        was_locked = !m_fault && (m_streak >= LOCK_CNT);
        if (!m_fault) begin
            if (good) begin
                if (was_locked && prev == 6 && s == 0)
                    m_wrap = (m_wrap + 1) % (1 << WRAP_W);
                m_streak++;
            end else begin
                if (was_locked) begin
                    m_fault = 1;
                    if (m_err < (1 << ERR_W) - 1) m_err++;
                end
                m_streak = 0;
            end
        end
        q_hist.push_back(s);
        if (q_hist.size() > 4) void'(q_hist.pop_front());
        m_last = s;
    endfunction

    typedef struct {
        logic       en;
        logic       clr;
        logic [2:0] s;
        int         l;
        int         f;
        int         w;
        int         e;
        int         last;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic e, input logic c, input logic [2:0] s,
                                input int l, input int f, input int w, input int er,
                                input int last);
        vec_t v;
        v.en = e; v.clr = c; v.s = s;
        v.l = l; v.f = f; v.w = w; v.e = er; v.last = last;
        vecs.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_prev;
        string tag;

        // ---------------- directed vector table ----------------
        add(1, 0, 3'd0, 0, 0, 0, 0, 0);
        add(1, 0, 3'd1, 0, 0, 0, 0, 1);
        add(1, 0, 3'd2, 0, 0, 0, 0, 2);
        add(1, 0, 3'd3, 1, 0, 0, 0, 3);
        for (int k = 0; k < 21; k++)
            add(1, 0, 3'((4 + k) % 7), 1, 0,
                int'(k >= 3) + int'(k >= 10) + int'(k >= 17), 0, (4 + k) % 7);
        add(1, 0, 3'd5, 0, 1, 3, 1, 5);   // 5 where 4 expected
        add(1, 0, 3'd6, 0, 1, 3, 1, 6);
        add(1, 0, 3'd0, 0, 1, 3, 1, 0);
        add(1, 0, 3'd1, 0, 1, 3, 1, 1);
        add(1, 1, 3'd2, 0, 0, 0, 1, 1);   // clr discards the sample
        add(1, 0, 3'd3, 0, 0, 0, 1, 3);
        add(1, 0, 3'd4, 0, 0, 0, 1, 4);
        add(1, 0, 3'd5, 0, 0, 0, 1, 5);
        add(1, 0, 3'd6, 1, 0, 0, 1, 6);
        add(0, 0, 3'd3, 1, 0, 0, 1, 6);   // en=0 holds
        add(1, 0, 3'd0, 1, 0, 1, 1, 0);
        add(1, 0, 3'd7, 0, 1, 1, 2, 7);   // illegal code
        add(0, 1, 3'd5, 0, 0, 0, 2, 7);   // clr acts with en=0
        add(1, 0, 3'd1, 0, 0, 0, 2, 1);
        add(1, 0, 3'd2, 0, 0, 0, 2, 2);
        add(1, 0, 3'd2, 0, 0, 0, 2, 2);   // stall in HUNT restarts the run
        add(1, 0, 3'd3, 0, 0, 0, 2, 3);
        add(1, 0, 3'd4, 0, 0, 0, 2, 4);
        add(1, 0, 3'd5, 1, 0, 0, 2, 5);
        add(1, 0, 3'd5, 0, 1, 0, 3, 5);   // stall while locked

        rst = 1'b0; en = 1'b0; clr = 1'b0; state_in = 3'd0;
        #12;
        chk_all("reset", 0, 0, 0, 0, 0);
`ifdef MOD7_SEG_DECODE_EN
        chk("reset.seg", 32'(seg), 32'(seg_of(0)));
`endif
        rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].clr, vecs[i].s);
            $display("vec %0d: en=%0d clr=%0d s=%0d -> locked=%0d fault=%0d wrap=%0d err=%0d last=%0d",
                     i, vecs[i].en, vecs[i].clr, vecs[i].s, locked, fault, wrap_cnt, err_cnt, last_state);
            tag = $sformatf("vec%0d", i);
            chk_all(tag, vecs[i].l, vecs[i].f, vecs[i].w, vecs[i].e, vecs[i].last);
`ifdef MOD7_SEG_DECODE_EN
            chk({tag, ".seg"}, 32'(seg),
                32'(vecs[i].f ? 7'b0000001 : seg_of(vecs[i].last)));
`endif
        end

        // ---------------- err_cnt saturation ----------------
        for (int r = 0; r < 16; r++) begin
            drive(1, 1, 3'd0);
            for (int k = 0; k < 4; k++) drive(1, 0, 3'(k));
            chk($sformatf("round%0d.locked", r), 32'(locked), 32'd1);
            drive(1, 0, 3'd5);
            chk($sformatf("round%0d.fault", r), 32'(fault), 32'd1);
            chk($sformatf("round%0d.err_cnt", r), 32'(err_cnt), 32'((4 + r > 15) ? 15 : 4 + r));
            $display("round %0d: err_cnt=%0d", r, err_cnt);
        end

        // ---------------- async reset while locked, then en=0 hold ----------------
        drive(1, 1, 3'd0);
        for (int k = 0; k < 4; k++) drive(1, 0, 3'(k));
        for (int k = 0; k < 32; k++) drive(1, 0, 3'((4 + k) % 7));
        chk_all("prereset", 1, 0, 5, 15, 0);
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
`ifdef MOD7_SEG_DECODE_EN
        chk("async_rst.seg", 32'(seg), 32'(seg_of(0)));
`endif
        $display("async reset: locked=%0d wrap=%0d err=%0d", locked, wrap_cnt, err_cnt);
        en = 1'b0;
        #4;
        rst = 1'b1;
        drive(1, 0, 3'd0);
        drive(1, 0, 3'd1);
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 3'($urandom_range(7)));
            chk_all($sformatf("hold%0d", k), 0, 0, 0, 0, 1);
        end
        drive(1, 0, 3'd2);
        chk("resume.locked_early", 32'(locked), 32'd0);
        drive(1, 0, 3'd3);
        chk("resume.locked", 32'(locked), 32'd1);

        // ---------------- randomized run vs. model ----------------
        #2; rst = 1'b0; #1;
        model_reset();
        #3; rst = 1'b1;
        s_prev = 0;
        for (int n = 0; n < 3000; n++) begin
            bit e, c;
            int s, r;
            e = ($urandom % 10) != 0;
            c = ($urandom % 40) == 0;
            r = $urandom % 100;
            s = (r < 85) ? (s_prev + 1) % 7 : ((r < 92) ? s_prev : int'($urandom % 8));
            s_prev = s;
            model_step(e, c, s);
            drive(e, c, 3'(s));
            tag = $sformatf("rnd%0d", n);
            chk_all(tag, int'(!m_fault && m_streak >= LOCK_CNT), int'(m_fault),
                    m_wrap, m_err, m_last);
`ifdef MOD7_SEG_DECODE_EN
            chk({tag, ".seg"}, 32'(seg), 32'(m_fault ? 7'b0000001 : seg_of(m_last)));
`endif
        end
        $display("random run: 3000 transactions, final wrap=%0d err=%0d", wrap_cnt, err_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
